// File: rtl/cache_control.sv
// Direct-mapped cache controller FSM: IDLE / WRITEBACK / ALLOCATE.
// Define CACHE_PERF_CNT_EN to build the saturating hit/miss counters.
module cache_control #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic                   hit,
    input  logic                   dirty,
    input  logic                   pmem_resp,
    output logic                   mem_resp,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic                   load_data,
    output logic                   load_tag,
    output logic                   load_valid,
    output logic                   load_dirty,
    output logic                   dirty_in,
    output logic                   datain_sel,
    output logic                   pmem_addr_sel,
    output logic [COUNT_WIDTH-1:0] hit_count,
    output logic [COUNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_e;

    state_e state_q, state_d;
    logic   req;

    assign req = mem_read | mem_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Outputs are gated by reset_n so they drop the instant reset asserts.
    always_comb begin
        state_d       = state_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        load_data     = 1'b0;
        load_tag      = 1'b0;
        load_valid    = 1'b0;
        load_dirty    = 1'b0;
        dirty_in      = 1'b0;
        datain_sel    = 1'b0;
        pmem_addr_sel = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            mem_resp = 1'b1;
                            if (mem_write) begin
                                load_data  = 1'b1;
                                load_dirty = 1'b1;
                                dirty_in   = 1'b1;
                            end
                        end else if (dirty) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (pmem_resp) state_d = ALLOCATE;
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_data  = 1'b1;
                        datain_sel = 1'b1;
                        load_tag   = 1'b1;
                        load_valid = 1'b1;
                        load_dirty = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [COUNT_WIDTH-1:0] hit_q, miss_q;
    logic                   pend_q;
    logic                   miss_ev, hit_ev;

    assign miss_ev = (state_q == IDLE) && (state_d != IDLE);
    // The hit that completes a refilled miss is not a real hit.
    assign hit_ev  = mem_resp && !pend_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q  <= '0;
            miss_q <= '0;
            pend_q <= 1'b0;
        end else begin
            if (miss_ev && (miss_q != '1)) miss_q <= miss_q + 1'b1;
            if (hit_ev && (hit_q != '1))   hit_q  <= hit_q + 1'b1;
            if (miss_ev)       pend_q <= 1'b1;
            else if (mem_resp) pend_q <= 1'b0;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
